// File: rtl/instr_mem_responder.sv
// Instruction memory responder for the core fetch interface.
// Word array with a fixed wait-state fetch latency and a side load port for program images.
module instr_mem_responder #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              Fetch_Req,
  input  logic [DWIDTH-1:0] Fetch_Addr,
  output logic              Fetch_Ready,
  output logic              Instr_Valid,
  output logic [31:0]       Instruction,
  output logic              Instr_Fault,
  input  logic              Load_En,
  input  logic [DWIDTH-1:0] Load_Addr,
  input  logic [31:0]       Load_Data,
  output logic              Load_Ack,
  output logic              Load_Err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] read_addr;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       instr_q;
  logic              fault_q;
  logic              load_ack_q, load_err_q;
  logic              accept, enter_resp, read_bad, load_ok;

  // Misaligned, or any word-index bit above the array range set.
  function automatic logic addr_bad(input logic [DWIDTH-1:0] a);
    logic [DWIDTH-1:0] hi;
    hi = a >> (AW + 2);
    return (a[1:0] != 2'b00) || (hi != '0);
  endfunction

  assign Fetch_Ready = (state_q == StIdle) && !Load_En;
  assign accept      = Fetch_Req && Fetch_Ready;
  assign enter_resp  = (state_d == StResp);
  // With zero wait states the read happens on the accept edge, before addr_q is latched.
  assign read_addr   = (state_q == StIdle) ? Fetch_Addr : addr_q;
  assign read_bad    = addr_bad(read_addr);
  assign load_ok     = Load_En && !addr_bad(Load_Addr);

  assign Instr_Valid = (state_q == StResp);
  assign Instruction = instr_q;
  assign Instr_Fault = fault_q;
  assign Load_Ack    = load_ack_q;
  assign Load_Err    = load_err_q;

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state, latched address, response registers and load pulses.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      instr_q    <= RESET_INSTR;
      fault_q    <= 1'b0;
      load_ack_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= Fetch_Addr;
      end
      // Array read on the RESP-entry edge; a same-edge load is seen as old data.
      if (enter_resp) begin
        fault_q <= read_bad;
        instr_q <= read_bad ? RESET_INSTR : mem[read_addr[AW+1:2]];
      end
      load_ack_q <= load_ok;
      load_err_q <= Load_En && !load_ok;
    end
  end

  // Program array write; contents deliberately survive reset.
  always_ff @(posedge Clk_Core) begin
    if (load_ok) begin
      mem[Load_Addr[AW+1:2]] <= Load_Data;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: dut 0 has one wait state, dut 1 has three (read-before-write timing).
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req   [2];
  logic [31:0] fetch_addr  [2];
  logic        fetch_ready [2];
  logic        instr_valid [2];
  logic [31:0] instruction [2];
  logic        instr_fault [2];
  logic        load_en     [2];
  logic [31:0] load_addr   [2];
  logic [31:0] load_data   [2];
  logic        load_ack    [2];
  logic        load_err    [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct { int dut; int cyc; logic [31:0] instr; logic fault; } fexp_t;
  typedef struct { int dut; int cyc; logic err; } lexp_t;
  fexp_t fq[$];
  lexp_t lq[$];

  instr_mem_responder #(.DWIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(1), .RESET_INSTR(NOP)) u_dut0 (
    .Clk_Core(clk), .Rst_Core(rst),
    .Fetch_Req(fetch_req[0]), .Fetch_Addr(fetch_addr[0]), .Fetch_Ready(fetch_ready[0]),
    .Instr_Valid(instr_valid[0]), .Instruction(instruction[0]), .Instr_Fault(instr_fault[0]),
    .Load_En(load_en[0]), .Load_Addr(load_addr[0]), .Load_Data(load_data[0]),
    .Load_Ack(load_ack[0]), .Load_Err(load_err[0])
  );

  instr_mem_responder #(.DWIDTH(32), .DEPTH_WORDS(64), .WAIT_STATES(3), .RESET_INSTR(NOP)) u_dut1 (
    .Clk_Core(clk), .Rst_Core(rst),
    .Fetch_Req(fetch_req[1]), .Fetch_Addr(fetch_addr[1]), .Fetch_Ready(fetch_ready[1]),
    .Instr_Valid(instr_valid[1]), .Instruction(instruction[1]), .Instr_Fault(instr_fault[1]),
    .Load_En(load_en[1]), .Load_Addr(load_addr[1]), .Load_Data(load_data[1]),
    .Load_Ack(load_ack[1]), .Load_Err(load_err[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a response or load pulse.
  int fidx, lidx;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (instr_valid[d] === 1'b1) begin
        fidx = -1;
        for (int i = 0; i < fq.size(); i++) if (fidx < 0 && fq[i].dut == d) fidx = i;
        if (fidx < 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_valid dut%0d: got Instr_Valid=1 expected 0 (cycle %0d)", d, cyc);
        end else begin
          chk($sformatf("valid_cycle dut%0d", d), 32'(cyc), 32'(fq[fidx].cyc));
          chk($sformatf("instruction dut%0d", d), instruction[d], fq[fidx].instr);
          chk($sformatf("instr_fault dut%0d", d), 32'(instr_fault[d]), 32'(fq[fidx].fault));
          fq.delete(fidx);
        end
      end
      if (load_ack[d] === 1'b1 || load_err[d] === 1'b1) begin
        lidx = -1;
        for (int i = 0; i < lq.size(); i++) if (lidx < 0 && lq[i].dut == d) lidx = i;
        if (lidx < 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_load_pulse dut%0d: got ack=%b err=%b expected none",
                   d, load_ack[d], load_err[d]);
        end else begin
          chk($sformatf("load_cycle dut%0d", d), 32'(cyc), 32'(lq[lidx].cyc));
          chk($sformatf("load_ack dut%0d", d), 32'(load_ack[d]), 32'(!lq[lidx].err));
          chk($sformatf("load_err dut%0d", d), 32'(load_err[d]), 32'(lq[lidx].err));
          lq.delete(lidx);
        end
      end
    end
    for (int i = fq.size() - 1; i >= 0; i--) begin
      if (fq[i].cyc < cyc) begin
        n_checks++; n_errors++;
        $display("FAIL missed_valid dut%0d: got no response expected one at cycle %0d",
                 fq[i].dut, fq[i].cyc);
        fq.delete(i);
      end
    end
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].cyc < cyc) begin
        n_checks++; n_errors++;
        $display("FAIL missed_load_pulse dut%0d: got none expected one at cycle %0d",
                 lq[i].dut, lq[i].cyc);
        lq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() != 0 || lq.size() != 0) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (fq.size() != 0 || lq.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", fq.size() + lq.size());
    end
    tick();
  endtask

  task automatic issue_fetch(input int d, input logic [31:0] a, input logic [31:0] ins,
                             input logic f, input int ws);
    fetch_req[d]  = 1'b1;
    fetch_addr[d] = a;
    @(negedge clk);
    chk($sformatf("fetch_ready dut%0d", d), 32'(fetch_ready[d]), 32'd1);
    fq.push_back('{d, cyc + 1 + ws, ins, f});
    tick();
    fetch_req[d] = 1'b0;
  endtask

  task automatic do_fetch(input int d, input logic [31:0] a, input logic [31:0] ins,
                          input logic f, input int ws);
    issue_fetch(d, a, ins, f, ws);
    drain();
  endtask

  task automatic do_load(input int d, input logic [31:0] a, input logic [31:0] v, input logic e);
    load_en[d]   = 1'b1;
    load_addr[d] = a;
    load_data[d] = v;
    lq.push_back('{d, cyc + 1, e});
    tick();
    load_en[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      fetch_req[d] = 1'b0; fetch_addr[d] = '0;
      load_en[d] = 1'b0; load_addr[d] = '0; load_data[d] = '0;
    end

    // Reset state.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_instruction dut%0d", d), instruction[d], NOP);
      chk($sformatf("reset_ready dut%0d", d), 32'(fetch_ready[d]), 32'd1);
      chk($sformatf("reset_pulses dut%0d", d),
          32'({instr_valid[d], instr_fault[d], load_ack[d], load_err[d]}), 32'd0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Load then fetch; latency N+2 with one wait state.
    do_load(0, 32'h0, 32'h00500093, 1'b0);
    do_load(0, 32'h4, 32'h00a00113, 1'b0);
    drain();
    do_fetch(0, 32'h0, 32'h00500093, 1'b0, 1);
    do_fetch(0, 32'h4, 32'h00a00113, 1'b0, 1);

    // Faults and rejected loads.
    do_fetch(0, 32'h2, NOP, 1'b1, 1);
    do_fetch(0, 32'h1000, NOP, 1'b1, 1);
    do_load(0, 32'h3, 32'hffffffff, 1'b1);
    do_load(0, 32'h1000, 32'hffffffff, 1'b1);
    drain();
    do_fetch(0, 32'h0, 32'h00500093, 1'b0, 1);

    // Load blocks fetch acceptance in the same cycle.
    fetch_req[0] = 1'b1; fetch_addr[0] = 32'h8;
    load_en[0] = 1'b1; load_addr[0] = 32'h8; load_data[0] = 32'h12345678;
    lq.push_back('{0, cyc + 1, 1'b0});
    @(negedge clk);
    chk("ready_during_load dut0", 32'(fetch_ready[0]), 32'd0);
    tick();
    load_en[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_load dut0", 32'(fetch_ready[0]), 32'd1);
    fq.push_back('{0, cyc + 2, 32'h12345678, 1'b0});
    tick();
    fetch_req[0] = 1'b0;
    drain();

    // Read-before-write on the RESP-entry edge (three wait states).
    do_load(1, 32'h10, 32'h0000a0b7, 1'b0);
    drain();
    issue_fetch(1, 32'h10, 32'h0000a0b7, 1'b0, 3);
    tick();
    tick();
    do_load(1, 32'h10, 32'hdeadbeef, 1'b0);
    drain();
    do_fetch(1, 32'h10, 32'hdeadbeef, 1'b0, 3);
    do_load(1, 32'h10, 32'h11111111, 1'b0);
    drain();
    issue_fetch(1, 32'h10, 32'hcafef00d, 1'b0, 3);
    tick();
    do_load(1, 32'h10, 32'hcafef00d, 1'b0);
    drain();

    // Reset during WAIT aborts the fetch; contents survive.
    fetch_req[0] = 1'b1; fetch_addr[0] = 32'h4;
    tick();
    fetch_req[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_reset_instruction dut0", instruction[0], NOP);
    chk("async_reset_ready dut0", 32'(fetch_ready[0]), 32'd1);
    chk("async_reset_pulses dut0", 32'({instr_valid[0], instr_fault[0]}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    do_fetch(0, 32'h0, 32'h00500093, 1'b0, 1);
    do_fetch(1, 32'h10, 32'hcafef00d, 1'b0, 3);

    chk("scoreboard_empty", 32'(fq.size() + lq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
